snake_body: RTL

- Upstream stage of the pixel generator. Tracks the snake as a circular buffer of cell positions.
- On each game tick it computes the new head from the requested direction, checks for wall and self collision, and handles eating and growth.
- It presents the head position, tail position and grow flag that the pixel generator consumes to set and clear cells.
- Position format everywhere: 8 bits, {row[3:0], col[3:0]}, row 0..GRID_H-1, col 0..GRID_W-1.

---
 rtl/snake_body.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/snake_body.sv
// Snake body tracker: circular buffer of cell positions, advanced one cell per
// game tick, with wall/self collision detection and growth on eating food.
module snake_body #(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             step,
    input  logic [1:0]                       dir,
    input  logic [7:0]                       food_pos,
    output logic [7:0]                       head_pos,
    output logic [7:0]                       tail_pos,
    output logic                             grow,
    output logic [$clog2(MAX_LEN+1)-1:0]     length,
    output logic                             busy,
    output logic                             step_done,
    output logic                             game_over
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int PTR_W = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [3:0]       START_ROW = 4'd3;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, SCAN, COMMIT} state_t;

    state_t           state;
    logic [7:0]       mem [MAX_LEN];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] scan_ptr;
    logic [LEN_W-1:0] scan_cnt;
    logic [1:0]       cur_dir;
    logic [7:0]       next_head;
    logic             eat;
    logic             collide;

    logic [7:0]       calc_next;
    logic             wall;
    logic             eat_now;
    logic [3:0]       row;
    logic [3:0]       col;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        row       = head_pos[7:4];
        col       = head_pos[3:0];
        calc_next = head_pos;
        wall      = 1'b0;
        case (cur_dir)
            DIR_UP: begin
                wall      = (row == 4'd0);
                calc_next = {row - 4'd1, col};
            end
            DIR_RIGHT: begin
                wall      = (col == 4'(GRID_W - 1));
                calc_next = {row, col + 4'd1};
            end
            DIR_DOWN: begin
                wall      = (row == 4'(GRID_H - 1));
                calc_next = {row + 4'd1, col};
            end
            DIR_LEFT: begin
                wall      = (col == 4'd0);
                calc_next = {row, col - 4'd1};
            end
        endcase
        eat_now = (calc_next == food_pos) && (length < MAX_LEN_L);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            // NOTE: the segment buffer is reset deliberately: it must hold the
            // starting snake, so it is built from flops rather than a RAM.
            for (int i = 0; i < MAX_LEN; i++) begin
                mem[i] <= (i < INIT_LEN) ? {START_ROW, 4'(i)} : 8'h00;
            end
            head_ptr  <= PTR_W'(INIT_LEN - 1);
            tail_ptr  <= '0;
            scan_ptr  <= '0;
            scan_cnt  <= '0;
            cur_dir   <= DIR_RIGHT;
            next_head <= 8'h00;
            eat       <= 1'b0;
            collide   <= 1'b0;
            head_pos  <= {START_ROW, 4'(INIT_LEN - 1)};
            tail_pos  <= {START_ROW, 4'd0};
            length    <= LEN_W'(INIT_LEN);
            grow      <= 1'b0;
            busy      <= 1'b0;
            step_done <= 1'b0;
            game_over <= 1'b0;
        end else begin
            step_done <= 1'b0;
            grow      <= 1'b0;
            case (state)
                IDLE: begin
                    if (step && !game_over) begin
                        // A direct reversal would fold the head into the neck.
                        if (dir != (cur_dir ^ 2'b10)) cur_dir <= dir;
                        collide <= 1'b0;
                        eat     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    next_head <= calc_next;
                    scan_ptr  <= head_ptr;
                    if (wall) begin
                        collide <= 1'b1;
                        state   <= COMMIT;
                    end else begin
                        eat      <= eat_now;
                        scan_cnt <= eat_now ? length : length - LEN_W'(1);
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    // Walk newest to oldest; the vacating tail is outside the count.
                    if (mem[scan_ptr] == next_head) collide <= 1'b1;
                    scan_ptr <= scan_ptr - PTR_W'(1);
                    scan_cnt <= scan_cnt - LEN_W'(1);
                    if (scan_cnt == LEN_W'(1)) state <= COMMIT;
                end
                COMMIT: begin
                    if (collide) begin
                        game_over <= 1'b1;
                    end else begin
                        mem[head_ptr + PTR_W'(1)] <= next_head;
                        head_ptr <= head_ptr + PTR_W'(1);
                        head_pos <= next_head;
                        if (eat) begin
                            length <= length + LEN_W'(1);
                            grow   <= 1'b1;
                        end else begin
                            tail_ptr <= tail_ptr + PTR_W'(1);
                            tail_pos <= mem[tail_ptr + PTR_W'(1)];
                        end
                    end
                    step_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
